// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_LD_STALL = 3'd1,
        ST_RAW_WAIT = 3'd2,
        ST_MEM_WAIT = 3'd3,
        ST_FLUSH    = 3'd4
    } state_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_XM  = 2'b01;
    localparam logic [1:0] FWD_MW  = 2'b10;

    // Control word loaded into DX when a bubble is inserted.
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic branch;
    } dx_ctrl_t;

    localparam dx_ctrl_t NOP_CTRL = '{reg_write: 1'b0, mem_read: 1'b0, branch: 1'b0};

    function automatic logic reg_match(input logic we, input logic [4:0] rd, input logic [4:0] rs);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; used for the stall/flush performance counters.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && (q != {W{1'b1}}))
            q <= q + 1'b1;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Build option: define HAZARD_FORWARD_EN to resolve ALU RAW hazards by forwarding instead of stalling.
//
// state       | meaning
// ST_RUN      | normal issue; hazards, memory wait and branches detected here
// ST_LD_STALL | cycle after the single load-use bubble
// ST_RAW_WAIT | extra stall cycles until the producer is written back (cnt counts down)
// ST_MEM_WAIT | pipeline frozen while data memory is busy
// ST_FLUSH    | extra squash cycles after a taken branch (cnt counts down)
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RAW_WAIT_CYC = 3,
    parameter int FLUSH_CYC    = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [4:0]       DX_RD,
    input  logic             DX_RegWrite,
    input  logic             DX_MemRead,
    input  logic [4:0]       XM_RD,
    input  logic             XM_RegWrite,
    input  logic             XF_Branch,
    input  logic             mem_busy,
    output logic             pc_hold,
    output logic             dx_bubble,
    output logic             flush_fd,
    output logic             flush_dx,
    output logic             xm_hold,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYC - 1);
    localparam logic [2:0] RAW_RELOAD   = 3'(RAW_WAIT_CYC - 1);

    state_t     state, nxt_state;
    logic [2:0] cnt, nxt_cnt;

    logic pc_hold_c, dx_bubble_c, flush_c, xm_hold_c, flush_inc;
    logic m_dx_a, m_dx_b, m_xm_a, m_xm_b;
    logic hz_dx, hz_xm, stall_hz;
    logic [2:0] stall_reload;
    state_t     stall_state;

    assign m_dx_a = reg_match(DX_RegWrite, DX_RD, id_rs);
    assign m_dx_b = id_uses_rt && reg_match(DX_RegWrite, DX_RD, id_rt);
    assign m_xm_a = reg_match(XM_RegWrite, XM_RD, id_rs);
    assign m_xm_b = id_uses_rt && reg_match(XM_RegWrite, XM_RD, id_rt);
    assign hz_dx  = m_dx_a || m_dx_b;
    assign hz_xm  = m_xm_a || m_xm_b;

`ifdef HAZARD_FORWARD_EN
    assign stall_hz     = hz_dx && DX_MemRead;
    assign stall_reload = 3'd0;
    assign stall_state  = ST_LD_STALL;
`else
    logic unused_mem_read;
    assign unused_mem_read = DX_MemRead;
    assign stall_hz     = hz_dx || hz_xm;
    assign stall_reload = hz_dx ? RAW_RELOAD : 3'd1;
    // A zero reload means the detecting cycle alone covers the hazard.
    assign stall_state  = (stall_reload == 3'd0) ? ST_RUN : ST_RAW_WAIT;
`endif

    always_comb begin
        pc_hold_c   = 1'b0;
        dx_bubble_c = 1'b0;
        flush_c     = 1'b0;
        xm_hold_c   = 1'b0;
        flush_inc   = 1'b0;
        nxt_state   = state;
        nxt_cnt     = cnt;
        if (XF_Branch) begin
            flush_c   = 1'b1;
            flush_inc = 1'b1;
            if (FLUSH_CYC > 1) begin
                nxt_state = ST_FLUSH;
                nxt_cnt   = FLUSH_RELOAD;
            end else begin
                nxt_state = ST_RUN;
                nxt_cnt   = 3'd0;
            end
        end else begin
            case (state)
                ST_RUN, ST_LD_STALL: begin
                    nxt_state = ST_RUN;
                    if (mem_busy) begin
                        pc_hold_c = 1'b1;
                        xm_hold_c = 1'b1;
                        nxt_state = ST_MEM_WAIT;
                    end else if (state == ST_RUN && stall_hz) begin
                        pc_hold_c   = 1'b1;
                        dx_bubble_c = 1'b1;
                        nxt_state   = stall_state;
                        nxt_cnt     = stall_reload;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_busy) begin
                        pc_hold_c = 1'b1;
                        xm_hold_c = 1'b1;
                    end else begin
                        nxt_state = ST_RUN;
                    end
                end
                ST_RAW_WAIT: begin
                    if (cnt != 3'd0) begin
                        pc_hold_c   = 1'b1;
                        dx_bubble_c = 1'b1;
                        nxt_cnt     = cnt - 3'd1;
                    end
                    if (cnt <= 3'd1)
                        nxt_state = ST_RUN;
                end
                ST_FLUSH: begin
                    flush_c = 1'b1;
                    if (cnt != 3'd0)
                        nxt_cnt = cnt - 3'd1;
                    if (cnt <= 3'd1)
                        nxt_state = ST_RUN;
                end
                default: begin
                    nxt_state = ST_RUN;
                    nxt_cnt   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            cnt   <= 3'd0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
        end
    end

    // Outputs drop the moment reset asserts, regardless of the inputs.
    assign pc_hold   = rst_n && pc_hold_c;
    assign dx_bubble = rst_n && dx_bubble_c;
    assign flush_fd  = rst_n && flush_c;
    assign flush_dx  = rst_n && flush_c;
    assign xm_hold   = rst_n && xm_hold_c;

`ifdef HAZARD_FORWARD_EN
    logic [1:0] fwd_a_q, fwd_b_q;

    // Selects follow the ID instruction into EX; the DX producer then sits in XM and wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_q <= FWD_REG;
            fwd_b_q <= FWD_REG;
        end else if (!xm_hold_c) begin
            if (dx_bubble_c || flush_c) begin
                fwd_a_q <= FWD_REG;
                fwd_b_q <= FWD_REG;
            end else begin
                fwd_a_q <= m_dx_a ? FWD_XM : (m_xm_a ? FWD_MW : FWD_REG);
                fwd_b_q <= m_dx_b ? FWD_XM : (m_xm_b ? FWD_MW : FWD_REG);
            end
        end
    end

    assign fwd_a = fwd_a_q;
    assign fwd_b = fwd_b_q;
`else
    assign fwd_a = FWD_REG;
    assign fwd_b = FWD_REG;
`endif

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pc_hold),
        .clr   (1'b0),
        .q     (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rst_n && flush_inc),
        .clr   (1'b0),
        .q     (flush_cnt)
    );

endmodule
